// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin sharing of one I2C core among NREQ requesters
// Optional RUN-state watchdog on to_limit is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int NREQ = 4,
  parameter int TO_W = 20
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_cnt,
  output logic [NREQ-1:0]   req_grant,
  input  logic [NREQ*8-1:0] wr_data,
  input  logic [NREQ-1:0]   wr_valid,
  output logic [NREQ-1:0]   wr_ready,
  output logic [7:0]        rd_data,
  output logic [NREQ-1:0]   rd_valid,
  output logic [NREQ-1:0]   done,
  output logic              done_err,
  output logic [7:0]        core_addr,
  output logic [7:0]        core_cnt,
  output logic              core_start,
  output logic [7:0]        core_tx_data,
  output logic              core_tx_en,
  input  logic              core_tx_req,
  input  logic [7:0]        core_rx_data,
  input  logic              core_rx_vld,
  input  logic              core_done,
  input  logic              core_error,
  input  logic [TO_W-1:0]   to_limit
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_RUN, S_FIN} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [NREQ-1:0] owner_oh;
  logic [7:0]      tx_cnt;
  logic            txn_err;
  logic            tx_fire;
  logic            to_hit;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // First pending requester at or after the round-robin pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[rr_idx(rr_ptr, i)]) begin
        win_found = 1'b1;
        win_idx   = rr_idx(rr_ptr, i);
      end
    end
  end

  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner;

  // The registered core_tx_en doubles as the mandatory one-cycle gap between bytes.
  assign tx_fire = (state == S_RUN) && !core_addr[0] && core_tx_req && wr_valid[owner]
                   && !core_tx_en && (tx_cnt != core_cnt);

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (to_limit != '0) && (to_cnt == to_limit);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      to_cnt <= '0;
    end else if (state == S_LOAD) begin
      to_cnt <= '0;
    end else if (state == S_RUN) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_to_limit;

  assign unused_to_limit = ^to_limit;
  assign to_hit          = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      req_grant    <= '0;
      wr_ready     <= '0;
      rd_data      <= '0;
      rd_valid     <= '0;
      done         <= '0;
      done_err     <= 1'b0;
      core_addr    <= '0;
      core_cnt     <= '0;
      core_start   <= 1'b0;
      core_tx_data <= '0;
      core_tx_en   <= 1'b0;
      tx_cnt       <= '0;
      txn_err      <= 1'b0;
    end else begin
      core_start <= 1'b0;
      core_tx_en <= 1'b0;
      wr_ready   <= '0;
      rd_valid   <= '0;
      done       <= '0;
      done_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Grant survives through the done cycle, then drops here.
          req_grant <= '0;
          if (|req_valid) state <= S_ARB;
        end
        S_ARB: begin
          if (win_found) begin
            req_grant <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            owner     <= win_idx;
            rr_ptr    <= rr_idx(win_idx, 1);
            state     <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          core_addr  <= req_addr[{owner, 3'b000} +: 8];
          core_cnt   <= req_cnt[{owner, 3'b000} +: 8];
          core_start <= 1'b1;
          tx_cnt     <= '0;
          txn_err    <= 1'b0;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (tx_fire) begin
            core_tx_en   <= 1'b1;
            core_tx_data <= wr_data[{owner, 3'b000} +: 8];
            wr_ready     <= owner_oh;
            tx_cnt       <= tx_cnt + 8'd1;
          end
          if (core_rx_vld && core_addr[0]) begin
            rd_data  <= core_rx_data;
            rd_valid <= owner_oh;
          end
          if (core_error) txn_err <= 1'b1;
          if (core_done) begin
            state <= S_FIN;
          end else if (to_hit) begin
            txn_err <= 1'b1;
            state   <= S_FIN;
          end
        end
        S_FIN: begin
          done     <= owner_oh;
          done_err <= txn_err;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - scoreboard bench for i2c_txn_arbiter with a behavioural I2C core model
// Exercises the watchdog path when compiled with I2C_ARB_TIMEOUT_EN.
module tb_i2c_txn_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_cnt = '0;
  logic [3:0]  req_grant;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_valid = '0;
  logic [3:0]  wr_ready;
  logic [7:0]  rd_data;
  logic [3:0]  rd_valid;
  logic [3:0]  done;
  logic        done_err;
  logic [7:0]  core_addr;
  logic [7:0]  core_cnt;
  logic        core_start;
  logic [7:0]  core_tx_data;
  logic        core_tx_en;
  logic        core_tx_req = 1'b0;
  logic [7:0]  core_rx_data = '0;
  logic        core_rx_vld = 1'b0;
  logic        core_done = 1'b0;
  logic        core_error = 1'b0;
  logic [19:0] to_limit = '0;

  i2c_txn_arbiter #(.NREQ(4), .TO_W(20)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_cnt(req_cnt), .req_grant(req_grant),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .done_err(done_err),
    .core_addr(core_addr), .core_cnt(core_cnt), .core_start(core_start),
    .core_tx_data(core_tx_data), .core_tx_en(core_tx_en), .core_tx_req(core_tx_req),
    .core_rx_data(core_rx_data), .core_rx_vld(core_rx_vld), .core_done(core_done),
    .core_error(core_error), .to_limit(to_limit)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;

  // Scoreboard: expectations pushed by tests, observations pushed by the monitor in tick().
  logic [7:0]  exp_tx[$];
  logic [7:0]  obs_tx[$];
  logic [10:0] exp_rd[$];
  logic [10:0] obs_rd[$];
  logic [3:0]  exp_done[$];
  logic [3:0]  obs_done[$];
  logic [2:0]  exp_grant[$];
  logic [2:0]  obs_grant[$];

  int         grant_cyc = 0, start_cyc = 0, last_rd_cyc = 0, done_cyc = 0;
  int         wr_ready_cnt = 0, done_total = 0, drop_at = 1000000;
  bit         auto_drop = 1'b1;
  logic [3:0] prev_grant = '0;
  logic [7:0] obs_addr = '0, obs_cnt = '0;

  // Requester write data and core model state.
  logic [7:0] wbytes [4][4];
  int         wptr [4];
  bit         cm_active = 0, cm_read = 0, cm_nack = 0, cm_silent = 0, cm_extra = 0;
  int         cm_cnt = 0, cm_n = 0, cm_wait = 0, cm_linger = 0, cm_nack_t = 0;
  logic [7:0] cm_rx [4];

  logic [7:0]  a8, e8;
  logic [10:0] a11, e11;
  logic [3:0]  a4, e4;
  logic [2:0]  a3, e3;
  bit          ok;

  function automatic logic [2:0] oh2i(input logic [3:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
    cyc++;
    if (core_done) core_error = 1'b0;
    core_done   = 1'b0;
    core_rx_vld = 1'b0;
    if (!$onehot0(req_grant)) viol++;
    if (prev_grant != 0 && req_grant != 0 && req_grant != prev_grant) viol++;
    if (((wr_ready | rd_valid | done) & ~req_grant) != 0) viol++;
    if (req_grant != 0 && prev_grant == 0) begin
      obs_grant.push_back(oh2i(req_grant));
      grant_cyc = cyc;
    end
    prev_grant = req_grant;
    if (core_start) begin
      start_cyc = cyc; obs_addr = core_addr; obs_cnt = core_cnt;
      cm_active = 1; cm_cnt = int'(core_cnt); cm_read = core_addr[0];
      cm_n = 0; cm_wait = 0; cm_linger = 5; cm_nack_t = 0;
    end
    if (core_tx_en) begin
      obs_tx.push_back(core_tx_data);
      core_tx_req = 1'b0; cm_n++; cm_wait = 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_ready[i]) begin
        wr_ready_cnt++;
        if (wptr[i] < 3) wptr[i]++;
        wr_data[8*i +: 8] = wbytes[i][wptr[i]];
      end
    end
    if (|rd_valid) begin
      obs_rd.push_back({oh2i(rd_valid), rd_data});
      last_rd_cyc = cyc;
    end
    if (|done) begin
      obs_done.push_back({oh2i(done), done_err});
      done_cyc = cyc; done_total++;
      if (auto_drop) req_valid = req_valid & ~done;
      if (done_total >= drop_at) req_valid = '0;
    end
    if (cm_active && !cm_silent) begin
      if (cm_nack) begin
        cm_nack_t++;
        if (cm_nack_t == 2) core_error = 1'b1;
        if (cm_nack_t == 5) begin core_done = 1'b1; cm_active = 0; end
      end else if (cm_read) begin
        if (cm_n < cm_cnt) begin
          core_rx_vld = 1'b1; core_rx_data = cm_rx[cm_n]; cm_n++;
        end
        if (cm_n >= cm_cnt) begin core_done = 1'b1; cm_active = 0; end
      end else if (cm_n < cm_cnt) begin
        if (cm_wait > 0) cm_wait--;
        else core_tx_req = 1'b1;
      end else if (cm_extra && cm_linger > 0) begin
        core_tx_req = 1'b1; cm_linger--;
      end else begin
        core_tx_req = 1'b0; core_done = 1'b1; cm_active = 0;
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget, output bit hit);
    int b;
    b = 0;
    while (obs_done.size() < n && b < budget) begin tick(); b++; end
    hit = (obs_done.size() >= n);
  endtask

  task automatic clear_sb();
    exp_tx.delete(); obs_tx.delete(); exp_rd.delete(); obs_rd.delete();
    exp_done.delete(); obs_done.delete(); exp_grant.delete(); obs_grant.delete();
    wr_ready_cnt = 0; viol = 0;
    for (int i = 0; i < 4; i++) wptr[i] = 0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    tick(); tick();
    checks++;
    if ({req_grant, wr_ready, rd_data, rd_valid, done, done_err, core_addr, core_cnt,
         core_start, core_tx_data, core_tx_en} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero, grant=%b core_addr=%h", req_grant, core_addr);
    end
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    clear_sb();
    wbytes[0][0] = 8'h11; wbytes[0][1] = 8'h22; wbytes[0][2] = 8'h99; wbytes[0][3] = 8'h99;
    wr_data[7:0] = 8'h11; wr_valid[0] = 1'b1;
    req_addr[7:0] = 8'hA0; req_cnt[7:0] = 8'd2; req_valid[0] = 1'b1;
    cm_extra = 1;
    exp_grant.push_back(3'd0);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
    exp_done.push_back({3'd0, 1'b0});
    wait_done(1, 200, ok);
    tick(); tick();
    cm_extra = 0; wr_valid = '0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_timeout: got no done, expected done within 200 cycles"); end
    checks++; if (start_cyc - grant_cyc !== 1) begin errors++; $display("FAIL wr_start_lat: got %0d expected 1", start_cyc - grant_cyc); end
    checks++; if ({obs_addr, obs_cnt} !== 16'hA002) begin errors++; $display("FAIL wr_core_load: got %h expected a002", {obs_addr, obs_cnt}); end
    checks++; if (wr_ready_cnt !== 2) begin errors++; $display("FAIL wr_ready_cnt: got %0d expected 2", wr_ready_cnt); end
    while (exp_grant.size() > 0) begin
      e3 = exp_grant.pop_front(); checks++;
      if (obs_grant.size() == 0) begin errors++; $display("FAIL wr_grant: got none expected %0d", e3); end
      else begin a3 = obs_grant.pop_front(); if (a3 !== e3) begin errors++; $display("FAIL wr_grant: got %0d expected %0d", a3, e3); end end
    end
    while (exp_tx.size() > 0) begin
      e8 = exp_tx.pop_front(); checks++;
      if (obs_tx.size() == 0) begin errors++; $display("FAIL wr_tx_byte: got none expected %h", e8); end
      else begin a8 = obs_tx.pop_front(); if (a8 !== e8) begin errors++; $display("FAIL wr_tx_byte: got %h expected %h", a8, e8); end end
    end
    checks++; if (obs_tx.size() !== 0) begin errors++; $display("FAIL wr_extra_bytes: got %0d extra expected 0", obs_tx.size()); end
    while (exp_done.size() > 0) begin
      e4 = exp_done.pop_front(); checks++;
      if (obs_done.size() == 0) begin errors++; $display("FAIL wr_done: got none expected %h", e4); end
      else begin a4 = obs_done.pop_front(); if (a4 !== e4) begin errors++; $display("FAIL wr_done: got %h expected %h", a4, e4); end end
    end
    checks++; if (req_grant !== 4'b0000) begin errors++; $display("FAIL wr_grant_release: got %b expected 0000", req_grant); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL wr_owner_rules: got %0d violations expected 0", viol); end
  endtask

  task automatic test_read();
    clear_sb();
    cm_rx[0] = 8'h5A; cm_rx[1] = 8'h5B; cm_rx[2] = 8'h5C;
    req_addr[23:16] = 8'hA1; req_cnt[23:16] = 8'd3; req_valid[2] = 1'b1;
    for (int k = 0; k < 3; k++) exp_rd.push_back({3'd2, cm_rx[k]});
    exp_done.push_back({3'd2, 1'b0});
    wait_done(1, 200, ok);
    tick(); tick();
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_timeout: got no done, expected done within 200 cycles"); end
    while (exp_rd.size() > 0) begin
      e11 = exp_rd.pop_front(); checks++;
      if (obs_rd.size() == 0) begin errors++; $display("FAIL rd_byte: got none expected %h", e11); end
      else begin a11 = obs_rd.pop_front(); if (a11 !== e11) begin errors++; $display("FAIL rd_byte: got %h expected %h", a11, e11); end end
    end
    checks++; if (done_cyc - last_rd_cyc !== 1) begin errors++; $display("FAIL rd_done_after_last: got %0d expected 1", done_cyc - last_rd_cyc); end
    while (exp_done.size() > 0) begin
      e4 = exp_done.pop_front(); checks++;
      if (obs_done.size() == 0) begin errors++; $display("FAIL rd_done: got none expected %h", e4); end
      else begin a4 = obs_done.pop_front(); if (a4 !== e4) begin errors++; $display("FAIL rd_done: got %h expected %h", a4, e4); end end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rd_owner_rules: got %0d violations expected 0", viol); end
  endtask

  task automatic test_nack();
    clear_sb();
    wr_data[31:24] = 8'h77; wr_valid[3] = 1'b1;
    req_addr[31:24] = 8'h50; req_cnt[31:24] = 8'd2; req_valid[3] = 1'b1;
    cm_nack = 1;
    exp_done.push_back({3'd3, 1'b1});
    wait_done(1, 200, ok);
    tick(); tick();
    cm_nack = 0; wr_valid = '0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nack_timeout: got no done, expected done within 200 cycles"); end
    while (exp_done.size() > 0) begin
      e4 = exp_done.pop_front(); checks++;
      if (obs_done.size() == 0) begin errors++; $display("FAIL nack_done: got none expected %h", e4); end
      else begin a4 = obs_done.pop_front(); if (a4 !== e4) begin errors++; $display("FAIL nack_done: got %h expected %h", a4, e4); end end
    end
    checks++; if (obs_tx.size() !== 0) begin errors++; $display("FAIL nack_tx: got %0d bytes expected 0", obs_tx.size()); end
    checks++; if (core_error !== 1'b0 || viol !== 0) begin errors++; $display("FAIL nack_owner_rules: got %0d violations expected 0", viol); end
  endtask

  task automatic test_round_robin();
    clear_sb();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) wbytes[i][k] = 8'h30 + 8'(i);
      wr_data[8*i +: 8] = 8'h30 + 8'(i);
      req_addr[8*i +: 8] = 8'h40 + 8'(2*i);
      req_cnt[8*i +: 8] = 8'd1;
    end
    for (int k = 0; k < 5; k++) begin
      exp_grant.push_back(3'(k % 4));
      exp_tx.push_back(8'h30 + 8'(k % 4));
      exp_done.push_back({3'(k % 4), 1'b0});
    end
    auto_drop = 0; drop_at = done_total + 5;
    wr_valid = 4'hF; req_valid = 4'hF;
    wait_done(5, 600, ok);
    tick(); tick();
    auto_drop = 1; drop_at = 1000000; wr_valid = '0;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_timeout: got %0d dones expected 5", obs_done.size()); end
    while (exp_grant.size() > 0) begin
      e3 = exp_grant.pop_front(); checks++;
      if (obs_grant.size() == 0) begin errors++; $display("FAIL rr_grant: got none expected %0d", e3); end
      else begin a3 = obs_grant.pop_front(); if (a3 !== e3) begin errors++; $display("FAIL rr_grant: got %0d expected %0d", a3, e3); end end
    end
    while (exp_tx.size() > 0) begin
      e8 = exp_tx.pop_front(); checks++;
      if (obs_tx.size() == 0) begin errors++; $display("FAIL rr_tx_byte: got none expected %h", e8); end
      else begin a8 = obs_tx.pop_front(); if (a8 !== e8) begin errors++; $display("FAIL rr_tx_byte: got %h expected %h", a8, e8); end end
    end
    while (exp_done.size() > 0) begin
      e4 = exp_done.pop_front(); checks++;
      if (obs_done.size() == 0) begin errors++; $display("FAIL rr_done: got none expected %h", e4); end
      else begin a4 = obs_done.pop_front(); if (a4 !== e4) begin errors++; $display("FAIL rr_done: got %h expected %h", a4, e4); end end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rr_owner_rules: got %0d violations expected 0", viol); end
  endtask

  task automatic test_reset_mid_run();
    int b;
    clear_sb();
    req_addr[23:16] = 8'hA1; req_cnt[23:16] = 8'd3; req_valid[2] = 1'b1;
    cm_silent = 1;
    b = 0;
    while (obs_grant.size() == 0 && b < 50) begin tick(); b++; end
    tick(); tick(); tick();
    checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b expected 0100", req_grant); end
    PRESETn = 1'b0;
    tick(); tick();
    checks++;
    if ({req_grant, wr_ready, rd_data, rd_valid, done, done_err, core_addr, core_cnt,
         core_start, core_tx_data, core_tx_en} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got nonzero, grant=%b core_addr=%h", req_grant, core_addr);
    end
    req_valid = '0; cm_active = 0; cm_silent = 0;
    PRESETn = 1'b1;
    tick(); tick();
    checks++; if (obs_done.size() !== 0) begin errors++; $display("FAIL mid_no_done: got %0d dones expected 0", obs_done.size()); end
    obs_grant.delete();
    // rr pointer was 3 before reset; a reset pointer must pick requester 1 first.
    req_addr[15:8] = 8'h22; req_cnt[15:8] = 8'd0;
    req_addr[31:24] = 8'h66; req_cnt[31:24] = 8'd0;
    req_valid = 4'b1010;
    exp_grant.push_back(3'd1); exp_grant.push_back(3'd3);
    exp_done.push_back({3'd1, 1'b0}); exp_done.push_back({3'd3, 1'b0});
    wait_done(2, 300, ok);
    tick(); tick();
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_timeout: got %0d dones expected 2", obs_done.size()); end
    while (exp_grant.size() > 0) begin
      e3 = exp_grant.pop_front(); checks++;
      if (obs_grant.size() == 0) begin errors++; $display("FAIL mid_rr_grant: got none expected %0d", e3); end
      else begin a3 = obs_grant.pop_front(); if (a3 !== e3) begin errors++; $display("FAIL mid_rr_grant: got %0d expected %0d", a3, e3); end end
    end
    while (exp_done.size() > 0) begin
      e4 = exp_done.pop_front(); checks++;
      if (obs_done.size() == 0) begin errors++; $display("FAIL mid_done: got none expected %h", e4); end
      else begin a4 = obs_done.pop_front(); if (a4 !== e4) begin errors++; $display("FAIL mid_done: got %h expected %h", a4, e4); end end
    end
    checks++; if (obs_tx.size() !== 0) begin errors++; $display("FAIL mid_probe_tx: got %0d bytes expected 0", obs_tx.size()); end
  endtask

  task automatic test_timeout();
    clear_sb();
    req_addr[7:0] = 8'h70; req_cnt[7:0] = 8'd0; req_valid[0] = 1'b1;
    cm_silent = 1; to_limit = 20'd100;
`ifdef I2C_ARB_TIMEOUT_EN
    exp_done.push_back({3'd0, 1'b1});
    wait_done(1, 400, ok);
    tick();
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_timeout: got no done, expected watchdog done"); end
    checks++;
    if (done_cyc - start_cyc < 100 || done_cyc - start_cyc > 103) begin
      errors++; $display("FAIL to_latency: got %0d cycles expected 100..103", done_cyc - start_cyc);
    end
    while (exp_done.size() > 0) begin
      e4 = exp_done.pop_front(); checks++;
      if (obs_done.size() == 0) begin errors++; $display("FAIL to_done: got none expected %h", e4); end
      else begin a4 = obs_done.pop_front(); if (a4 !== e4) begin errors++; $display("FAIL to_done: got %h expected %h", a4, e4); end end
    end
    cm_active = 0; cm_silent = 0;
    core_done = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (obs_done.size() !== 0 || req_grant !== 4'b0000) begin
      errors++; $display("FAIL to_late_core_done: got %0d dones grant=%b expected 0 dones grant 0000", obs_done.size(), req_grant);
    end
`else
    for (int k = 0; k < 150; k++) tick();
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL to_grant_held: got %b expected 0001", req_grant); end
    checks++; if (obs_done.size() !== 0) begin errors++; $display("FAIL to_no_done: got %0d dones expected 0", obs_done.size()); end
    exp_done.push_back({3'd0, 1'b0});
    cm_silent = 0;
    wait_done(1, 50, ok);
    tick();
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_release: got no done, expected done after core_done"); end
    while (exp_done.size() > 0) begin
      e4 = exp_done.pop_front(); checks++;
      if (obs_done.size() == 0) begin errors++; $display("FAIL to_done: got none expected %h", e4); end
      else begin a4 = obs_done.pop_front(); if (a4 !== e4) begin errors++; $display("FAIL to_done: got %h expected %h", a4, e4); end end
    end
`endif
    to_limit = '0;
    checks++; if (viol !== 0) begin errors++; $display("FAIL to_owner_rules: got %0d violations expected 0", viol); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      wptr[i] = 0;
      cm_rx[i] = 8'h00;
      for (int k = 0; k < 4; k++) wbytes[i][k] = 8'h00;
    end
    test_reset();
    test_single_write();
    test_read();
    test_nack();
    test_round_robin();
    test_reset_mid_run();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
